// File: rtl/dcache_pkg.sv
// dcache_pkg: shared state encoding and address constants for the data-cache refill controller
package dcache_pkg;
    typedef enum logic [2:0] {IDLE, REQ, WAIT, FILL, REPLAY, ERR} state_e;
    localparam int WORD_OFFSET = 2;
endpackage

// File: rtl/dcache_refill_ctrl_sat_counter.sv
// sat_counter: clearable up-counter that sticks at all-ones
module sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [WIDTH-1:0] count_o
);
    logic [WIDTH-1:0] count_q, count_d;
    always_comb count_d = clr_i ? '0 : (inc_i && count_q != '1) ? count_q + WIDTH'(1) : count_q;
    always_ff @(posedge clk) begin
        if (rst) count_q <= '0;
        else     count_q <= count_d;
    end
    assign count_o = count_q;
endmodule

// File: rtl/dcache_refill_ctrl.sv
// dcache_refill_ctrl: stalls on a cached-load miss, refills the word from memory and replays
module dcache_refill_ctrl
    import dcache_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_WIDTH      = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  useCacheM,
    input  logic                  cachehitM,
    input  logic [DATA_WIDTH-1:0] ALUResultM,
    output logic                  mem_req_o,
    output logic [DATA_WIDTH-1:0] mem_addr_o,
    input  logic                  mem_gnt_i,
    input  logic                  mem_ack_i,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i,
    output logic                  fill_we_o,
    output logic [DATA_WIDTH-1:0] fill_addr_o,
    output logic [DATA_WIDTH-1:0] fill_data_o,
    output logic                  stall_o,
    output logic                  bubble_w_o,
    output logic [CNT_WIDTH-1:0]  miss_count_o,
    output logic                  err_timeout_o
);
    localparam int TW = 16;
    state_e state_q, state_d;
    logic [DATA_WIDTH-1:0] addr_q, addr_d, data_q, data_d;
    logic [TW-1:0] tmo_cnt;
    logic miss, idle_miss;
    assign miss      = useCacheM & ~cachehitM;
    assign idle_miss = (state_q == IDLE) && miss;
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        data_d  = data_q;
        case (state_q)
            IDLE: begin
                if (miss) begin
                    state_d = REQ;
                    addr_d  = {ALUResultM[DATA_WIDTH-1:WORD_OFFSET], {WORD_OFFSET{1'b0}}};
                end
            end
            REQ:  state_d = mem_gnt_i ? WAIT : REQ;
            WAIT: begin
                if (mem_ack_i) begin
                    state_d = FILL;
                    data_d  = mem_rdata_i;
                end else if (tmo_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                    state_d = ERR;
                end
            end
            FILL:    state_d = REPLAY;
            REPLAY:  state_d = IDLE;
            ERR:     state_d = ERR;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end
    sat_counter #(.WIDTH(CNT_WIDTH)) u_miss_cnt (
        .clk(clk), .rst(rst), .clr_i(1'b0), .inc_i(idle_miss), .count_o(miss_count_o)
    );
    sat_counter #(.WIDTH(TW)) u_tmo_cnt (
        .clk(clk), .rst(rst), .clr_i(state_q != WAIT), .inc_i(state_q == WAIT), .count_o(tmo_cnt)
    );
    assign stall_o       = (state_q != IDLE) || miss;
    assign bubble_w_o    = stall_o;
    assign mem_req_o     = state_q == REQ;
    assign mem_addr_o    = mem_req_o ? addr_q : '0;
    assign fill_we_o     = state_q == FILL;
    assign fill_addr_o   = fill_we_o ? addr_q : '0;
    assign fill_data_o   = fill_we_o ? data_q : '0;
    assign err_timeout_o = state_q == ERR;
endmodule

// File: tb/tb_dcache_refill_ctrl.sv
// tb_dcache_refill_ctrl: vector table, corner sequences and randomized misses against a transaction model
module tb_dcache_refill_ctrl;
    localparam int T  = 8;
    localparam int CW = 4;
    logic clk = 0, rst = 1;
    logic useCacheM = 0, cachehitM = 0, mem_gnt_i = 0, mem_ack_i = 0;
    logic [31:0] ALUResultM = 0, mem_rdata_i = 0;
    logic mem_req_o, fill_we_o, stall_o, bubble_w_o, err_timeout_o;
    logic [31:0] mem_addr_o, fill_addr_o, fill_data_o;
    logic [CW-1:0] miss_count_o;
    int n_vec = 0, n_mis = 0, exp_cnt = 0;
    int r_stalls, r_fills, r_fill_cyc, r_err_cyc, r_addr_bad, r_req, r_bub_bad;
    logic [31:0] r_fa, r_fd, r_ma;

    dcache_refill_ctrl #(.DATA_WIDTH(32), .TIMEOUT_CYCLES(T), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst), .useCacheM(useCacheM), .cachehitM(cachehitM), .ALUResultM(ALUResultM),
        .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_gnt_i(mem_gnt_i), .mem_ack_i(mem_ack_i),
        .mem_rdata_i(mem_rdata_i), .fill_we_o(fill_we_o), .fill_addr_o(fill_addr_o),
        .fill_data_o(fill_data_o), .stall_o(stall_o), .bubble_w_o(bubble_w_o),
        .miss_count_o(miss_count_o), .err_timeout_o(err_timeout_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        int gd;
        int ad;
        logic [31:0] exp_addr;
        int exp_stall;
    } vec_t;
    vec_t vt[4];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic bump();
        exp_cnt = (exp_cnt < (1 << CW) - 1) ? exp_cnt + 1 : exp_cnt;
    endtask

    // One miss: gnt after gd REQ cycles, ack after ad WAIT cycles, optional spurious acks during REQ.
    task automatic run_miss(input logic [31:0] a, input logic [31:0] d, input int gd, input int ad,
                            input bit spur, input int maxc);
        int rc, wc;
        bit granted, acked;
        r_stalls = 0; r_fills = 0; r_fill_cyc = -1; r_err_cyc = -1; r_addr_bad = 0; r_req = 0;
        r_bub_bad = 0; r_ma = 'x; rc = 0; wc = 0; granted = 0; acked = 0;
        for (int c = 0; c < maxc; c++) begin
            @(negedge clk);
            useCacheM = (c == 0); cachehitM = 0; ALUResultM = a;
            mem_gnt_i = 0; mem_ack_i = 0; mem_rdata_i = d;
            if (granted && !acked) begin
                acked = (wc == ad);
                mem_ack_i = acked;
                wc++;
            end
            if (mem_req_o) begin
                if (r_req == 0) r_ma = mem_addr_o;
                else if (mem_addr_o !== r_ma) r_addr_bad++;
                r_req++;
                if (spur) begin mem_ack_i = 1; mem_rdata_i = ~d; end
                if (rc == gd) begin mem_gnt_i = 1; granted = 1; end
                rc++;
            end
            #1;
            if (bubble_w_o !== stall_o) r_bub_bad++;
            if (stall_o !== 1'b1) break;
            r_stalls++;
            if (fill_we_o) begin r_fills++; r_fill_cyc = c; r_fa = fill_addr_o; r_fd = fill_data_o; end
            if (err_timeout_o && r_err_cyc < 0) r_err_cyc = c;
        end
        useCacheM = 0; mem_gnt_i = 0; mem_ack_i = 0;
    endtask

    task automatic chk_reset_outputs(input string nm);
        chk({nm, "_req"}, 32'(mem_req_o), 0);
        chk({nm, "_maddr"}, mem_addr_o, 0);
        chk({nm, "_fwe"}, 32'(fill_we_o), 0);
        chk({nm, "_faddr"}, fill_addr_o, 0);
        chk({nm, "_fdata"}, fill_data_o, 0);
        chk({nm, "_cnt"}, 32'(miss_count_o), 0);
        chk({nm, "_err"}, 32'(err_timeout_o), 0);
        chk({nm, "_stall"}, 32'(stall_o), 0);
        chk({nm, "_bubble"}, 32'(bubble_w_o), 0);
    endtask

    initial begin
        vt[0] = '{32'h0000_1237, 32'hDEAD_BEEF, 0, 0, 32'h0000_1234, 5};
        vt[1] = '{32'h8000_0002, 32'h1234_5678, 3, 4, 32'h8000_0000, 12};
        vt[2] = '{32'hFFFF_FFFF, 32'hA5A5_A5A5, 1, 7, 32'hFFFF_FFFC, 13};
        vt[3] = '{32'h0000_0010, 32'h0000_0001, 0, 1, 32'h0000_0010, 6};

        repeat (2) @(posedge clk);
        @(negedge clk); rst = 0; #1;
        chk_reset_outputs("reset");

        @(negedge clk); useCacheM = 1; cachehitM = 1; ALUResultM = 32'h40; #1;
        chk("hit_stall", 32'(stall_o), 0);
        chk("hit_req", 32'(mem_req_o), 0);
        @(negedge clk); useCacheM = 0; cachehitM = 0; #1;
        chk("hit_cnt", 32'(miss_count_o), 0);
        chk("hit_req2", 32'(mem_req_o), 0);

        for (int i = 0; i < 4; i++) begin
            run_miss(vt[i].addr, vt[i].data, vt[i].gd, vt[i].ad, 0, 60);
            bump();
            chk($sformatf("tbl%0d_stalls", i), 32'(r_stalls), 32'(vt[i].exp_stall));
            chk($sformatf("tbl%0d_maddr", i), r_ma, vt[i].exp_addr);
            chk($sformatf("tbl%0d_reqcyc", i), 32'(r_req), 32'(vt[i].gd + 1));
            chk($sformatf("tbl%0d_addr_stable", i), 32'(r_addr_bad), 0);
            chk($sformatf("tbl%0d_fills", i), 32'(r_fills), 1);
            chk($sformatf("tbl%0d_fillcyc", i), 32'(r_fill_cyc), 32'(vt[i].exp_stall - 2));
            chk($sformatf("tbl%0d_faddr", i), r_fa, vt[i].exp_addr);
            chk($sformatf("tbl%0d_fdata", i), r_fd, vt[i].data);
            chk($sformatf("tbl%0d_bubble", i), 32'(r_bub_bad), 0);
            chk($sformatf("tbl%0d_cnt", i), 32'(miss_count_o), 32'(exp_cnt));
        end

        @(negedge clk); mem_ack_i = 1; mem_rdata_i = 32'h5555_5555; #1;
        chk("spur_idle_fwe", 32'(fill_we_o), 0);
        chk("spur_idle_stall", 32'(stall_o), 0);
        @(negedge clk); mem_ack_i = 0; #1;
        chk("spur_idle_fwe2", 32'(fill_we_o), 0);
        chk("spur_idle_req", 32'(mem_req_o), 0);

        run_miss(32'h0000_2001, 32'h0BAD_F00D, 2, 2, 1, 60);
        bump();
        chk("spur_req_stalls", 32'(r_stalls), 9);
        chk("spur_req_fills", 32'(r_fills), 1);
        chk("spur_req_fdata", r_fd, 32'h0BAD_F00D);
        chk("spur_req_faddr", r_fa, 32'h0000_2000);

        for (int i = 0; i < 20; i++) begin
            logic [31:0] a, d;
            int gd, ad;
            if ($urandom_range(1, 0) == 1) begin
                @(negedge clk); useCacheM = 1; cachehitM = 1; ALUResultM = $urandom; #1;
                chk("rnd_hit_stall", 32'(stall_o), 0);
                @(negedge clk); useCacheM = 0; cachehitM = 0; #1;
                chk("rnd_hit_req", 32'(mem_req_o), 0);
            end
            a = $urandom; d = $urandom;
            gd = $urandom_range(4, 0); ad = $urandom_range(T - 1, 0);
            run_miss(a, d, gd, ad, 0, 60);
            bump();
            chk("rnd_stalls", 32'(r_stalls), 32'(5 + gd + ad));
            chk("rnd_maddr", r_ma, a & ~32'h3);
            chk("rnd_addr_stable", 32'(r_addr_bad), 0);
            chk("rnd_fills", 32'(r_fills), 1);
            chk("rnd_fdata", r_fd, d);
            chk("rnd_faddr", r_fa, a & ~32'h3);
            chk("rnd_cnt", 32'(miss_count_o), 32'(exp_cnt));
        end

        run_miss(32'h0000_5005, 32'h1111_2222, 0, 1000, 0, 20);
        bump();
        chk("tmo_errcyc", 32'(r_err_cyc), 10);
        chk("tmo_stalls", 32'(r_stalls), 20);
        chk("tmo_fills", 32'(r_fills), 0);
        chk("tmo_req", 32'(mem_req_o), 0);
        chk("tmo_err", 32'(err_timeout_o), 1);
        chk("tmo_cnt", 32'(miss_count_o), 32'(exp_cnt));
        @(negedge clk); rst = 1;
        @(negedge clk); rst = 0; exp_cnt = 0; #1;
        chk_reset_outputs("tmo_rst");

        @(negedge clk); useCacheM = 1; cachehitM = 0; ALUResultM = 32'h3003; #1;
        @(negedge clk); useCacheM = 0; #1;
        chk("rstw_req", 32'(mem_req_o), 1);
        chk("rstw_maddr", mem_addr_o, 32'h3000);
        mem_gnt_i = 1;
        @(negedge clk); mem_gnt_i = 0;
        @(negedge clk); rst = 1;
        @(negedge clk); rst = 0; mem_ack_i = 1; mem_rdata_i = 32'hCAFE_F00D; #1;
        chk("rstw_fwe", 32'(fill_we_o), 0);
        chk("rstw_stall", 32'(stall_o), 0);
        chk("rstw_cnt", 32'(miss_count_o), 0);
        @(negedge clk); mem_ack_i = 0; #1;
        chk("rstw_fwe2", 32'(fill_we_o), 0);
        chk("rstw_stall2", 32'(stall_o), 0);
        chk("rstw_req2", 32'(mem_req_o), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end
endmodule
